swipt_axil_regs: RTL and testbench

//  AXI4-Lite slave register file for the SWIPT_2020 IP, S00_AXI port. Sits downstream of the PS/VIP
//  AXI master. Holds the coil-driver control words and exports them to the SWIPT power-transfer core.

---
 rtl/swipt_regs_pkg.sv | 32 +++
 rtl/swipt_axil_regs.sv | 219 +++++++++++++++++++++
 tb/tb_swipt_axil_regs.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/swipt_regs_pkg.sv
// rtl/swipt_regs_pkg.sv - shared response codes, FSM state types and byte-merge helper for swipt_axil_regs
package swipt_regs_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_GOT_AW = 2'd1,
    W_GOT_W  = 2'd2,
    W_RESP   = 2'd3
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Replace only the bytes whose strobe is set; the rest keep their old contents.
  function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/swipt_axil_regs.sv
// rtl/swipt_axil_regs.sv - AXI4-Lite register file for SWIPT coil-driver control words (option: SWIPT_REGS_STATUS_EN)
module swipt_axil_regs
  import swipt_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_NUM_REGS         = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [3:0]                      s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [32*C_NUM_REGS-1:0]        reg_o,
  output logic [C_NUM_REGS-1:0]           reg_wr_pulse_o,
  input  logic [31:0]                     status_i
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [31:0] NUM_REGS_U = 32'(C_NUM_REGS);

  wr_state_t        wr_state;
  rd_state_t        rd_state;
  logic [IDX_W-1:0] aw_idx_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [31:0]      regs [C_NUM_REGS];

  logic             aw_hs;
  logic             w_hs;
  logic             commit;
  logic [31:0]      commit_idx;
  logic [31:0]      commit_data;
  logic [3:0]       commit_strb;
  logic [1:0]       commit_resp;
  logic [31:0]      rd_idx;
  logic [31:0]      rd_word;

  // Protection bits and the byte offset inside a word carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]
`ifndef SWIPT_REGS_STATUS_EN
                           , status_i
`endif
                           };

  assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
  assign w_hs   = s00_axi_wvalid & s00_axi_wready;
  assign rd_idx = 32'(s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2]);

  // Select where the address and data of the completing write come from (live bus or captured half).
  always_comb begin
    commit      = 1'b0;
    commit_idx  = 32'(s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2]);
    commit_data = s00_axi_wdata;
    commit_strb = s00_axi_wstrb;
    case (wr_state)
      W_IDLE:   commit = aw_hs & w_hs;
      W_GOT_AW: begin
        commit     = w_hs;
        commit_idx = 32'(aw_idx_q);
      end
      W_GOT_W:  begin
        commit      = aw_hs;
        commit_data = wdata_q;
        commit_strb = wstrb_q;
      end
      default:  commit = 1'b0;
    endcase
    if (commit_idx < NUM_REGS_U) begin
      commit_resp = AXI_RESP_OKAY;
`ifdef SWIPT_REGS_STATUS_EN
    end else if (commit_idx == NUM_REGS_U) begin
      commit_resp = AXI_RESP_SLVERR;
`endif
    end else begin
      commit_resp = AXI_RESP_DECERR;
    end
  end

  // Word mux for the read path; unmapped indices read as zero.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < C_NUM_REGS; k++) begin
      if (rd_idx == k) rd_word = regs[k];
    end
  end

  // Write channel FSM plus register update and write pulses.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      wr_state        <= W_IDLE;
      s00_axi_awready <= 1'b1;
      s00_axi_wready  <= 1'b1;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_bresp   <= AXI_RESP_OKAY;
      aw_idx_q        <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      reg_wr_pulse_o  <= '0;
      for (int k = 0; k < C_NUM_REGS; k++) regs[k] <= '0;
    end else begin
      reg_wr_pulse_o <= '0;
      for (int k = 0; k < C_NUM_REGS; k++) begin
        if (commit && commit_resp == AXI_RESP_OKAY && commit_strb != 4'b0 && commit_idx == k) begin
          regs[k]           <= strb_merge(regs[k], commit_data, commit_strb);
          reg_wr_pulse_o[k] <= 1'b1;
        end
      end
      case (wr_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b1;
            s00_axi_bresp   <= commit_resp;
            wr_state        <= W_RESP;
          end else if (aw_hs) begin
            aw_idx_q        <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            s00_axi_awready <= 1'b0;
            wr_state        <= W_GOT_AW;
          end else if (w_hs) begin
            wdata_q         <= s00_axi_wdata;
            wstrb_q         <= s00_axi_wstrb;
            s00_axi_wready  <= 1'b0;
            wr_state        <= W_GOT_W;
          end
        end
        W_GOT_AW: begin
          if (w_hs) begin
            s00_axi_wready <= 1'b0;
            s00_axi_bvalid <= 1'b1;
            s00_axi_bresp  <= commit_resp;
            wr_state       <= W_RESP;
          end
        end
        W_GOT_W: begin
          if (aw_hs) begin
            s00_axi_awready <= 1'b0;
            s00_axi_bvalid  <= 1'b1;
            s00_axi_bresp   <= commit_resp;
            wr_state        <= W_RESP;
          end
        end
        default: begin
          if (s00_axi_bready) begin
            s00_axi_bvalid  <= 1'b0;
            s00_axi_awready <= 1'b1;
            s00_axi_wready  <= 1'b1;
            wr_state        <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Read channel FSM: capture data at AR handshake, hold until the master takes it.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      rd_state        <= R_IDLE;
      s00_axi_arready <= 1'b1;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
      s00_axi_rresp   <= AXI_RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (s00_axi_arvalid) begin
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b1;
            rd_state        <= R_DATA;
            if (rd_idx < NUM_REGS_U) begin
              s00_axi_rdata <= rd_word;
              s00_axi_rresp <= AXI_RESP_OKAY;
`ifdef SWIPT_REGS_STATUS_EN
            end else if (rd_idx == NUM_REGS_U) begin
              s00_axi_rdata <= status_i;
              s00_axi_rresp <= AXI_RESP_OKAY;
`endif
            end else begin
              s00_axi_rdata <= '0;
              s00_axi_rresp <= AXI_RESP_DECERR;
            end
          end
        end
        default: begin
          if (s00_axi_rready) begin
            s00_axi_rvalid  <= 1'b0;
            s00_axi_arready <= 1'b1;
            rd_state        <= R_IDLE;
          end
        end
      endcase
    end
  end

  // Flatten the register array onto the core-facing bus.
  for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_reg_out
    assign reg_o[32*k +: 32] = regs[k];
  end

endmodule

// File: tb/tb_swipt_axil_regs.sv
// tb/tb_swipt_axil_regs.sv - self-checking bench for swipt_axil_regs against a word/byte reference model
module tb_swipt_axil_regs;

  logic         clk = 1'b0;
  logic         areset;
  logic [4:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         arvalid, arready, rvalid, rready;
  logic [127:0] reg_o;
  logic [3:0]   pulse;
  logic [31:0]  status;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [4];

  always #5 clk = ~clk;

  swipt_axil_regs dut (
    .s00_axi_aclk(clk), .s00_axi_areset(areset),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .reg_o(reg_o), .reg_wr_pulse_o(pulse), .status_i(status)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  function automatic logic [1:0] exp_wresp(input logic [4:0] a);
    int idx = int'(a[4:2]);
    if (idx < 4) return 2'b00;
`ifdef SWIPT_REGS_STATUS_EN
    if (idx == 4) return 2'b10;
`endif
    return 2'b11;
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [4:0] a);
    int idx = int'(a[4:2]);
    if (idx < 4) return 2'b00;
`ifdef SWIPT_REGS_STATUS_EN
    if (idx == 4) return 2'b00;
`endif
    return 2'b11;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [4:0] a);
    int idx = int'(a[4:2]);
    if (idx < 4) return model[idx];
`ifdef SWIPT_REGS_STATUS_EN
    if (idx == 4) return status;
`endif
    return 32'h0;
  endfunction

  function automatic logic [3:0] exp_pulse(input logic [4:0] a, input logic [3:0] s);
    int idx = int'(a[4:2]);
    logic [3:0] p = 4'b0;
    if (idx < 4 && s != 4'b0) p[idx] = 1'b1;
    return p;
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a[4:2]);
    if (idx < 4) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model[idx] = (model[idx] & ~(32'hFF << (8*b))) | (d & (32'hFF << (8*b)));
      end
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
    logic [1:0] er;
    logic [3:0] ep;
    int n;
    er = exp_wresp(a);
    ep = exp_pulse(a, s);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
    check({tag, " aw_w_ready"}, {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(a, d, s);
    check({tag, " bvalid"}, bvalid, 1'b1);
    check({tag, " bresp"}, bresp, er);
    check({tag, " pulse"}, pulse, ep);
    check({tag, " reg_o"}, reg_o, model_flat());
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check({tag, " bvalid_clr"}, {bvalid, awready, wready, pulse}, {3'b011, 4'b0});
  endtask

  task automatic axi_read(input logic [4:0] a, input string tag);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    check({tag, " arready"}, arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check({tag, " rvalid"}, rvalid, 1'b1);
    check({tag, " rdata"}, rdata, exp_rdata(a));
    check({tag, " rresp"}, rresp, exp_rresp(a));
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check({tag, " rvalid_clr"}, {rvalid, arready}, 2'b01);
  endtask

  initial begin
    logic [31:0] old1, held;
    logic [1:0]  held_resp;
    areset = 1'b1;
    awaddr = '0; araddr = '0; awprot = 3'b010; arprot = 3'b101;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; wstrb = '0; status = 32'h0;
    for (int k = 0; k < 4; k++) model[k] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    areset = 1'b0;

    // reset state
    check("reset ready", {awready, wready, arready}, 3'b111);
    check("reset valid", {bvalid, rvalid}, 2'b00);
    check("reset resp_data", {bresp, rresp, rdata}, 36'h0);
    check("reset regs_pulse", {reg_o, pulse}, 132'h0);

    // four writes then readback
    for (int k = 0; k < 4; k++) axi_write(5'(4*k), 32'(k+1), 4'hF, $sformatf("t1 wr%0d", k));
    for (int k = 0; k < 4; k++) axi_read(5'(4*k), $sformatf("t1 rd%0d", k));

    // byte strobes
    axi_write(5'h00, 32'h00000001, 4'hF, "t2 init");
    axi_write(5'h00, 32'hAABBCCDD, 4'b0101, "t2 strb");
    check("t2 merged", reg_o[31:0], 32'h00BB00DD);
    axi_read(5'h00, "t2 rd");

    // W arrives three cycles ahead of AW
    @(negedge clk);
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    check("t3 wready_low", {wready, awready}, 2'b01);
    repeat (2) @(negedge clk);
    check("t3 no_bvalid", bvalid, 1'b0);
    @(negedge clk);
    awaddr = 5'h08; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    model_write(5'h08, 32'h12345678, 4'hF);
    check("t3 bvalid", {bvalid, bresp, awready, wready}, 5'b10000);
    check("t3 reg", reg_o, model_flat());
    check("t3 pulse", pulse, 4'b0100);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;

    // backpressure on B
    @(negedge clk);
    awaddr = 5'h0C; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    model_write(5'h0C, 32'hDEADBEEF, 4'hF);
    awaddr = 5'h04; wdata = 32'h55555555;
    held_resp = bresp;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t4 bstall%0d", i), {bvalid, bresp, awready, wready}, {1'b1, held_resp, 2'b00});
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("t4 no_stray_write", reg_o, model_flat());

    // backpressure on R
    @(negedge clk);
    araddr = 5'h0C; arvalid = 1'b1;
    @(posedge clk); #1;
    held = rdata;
    check("t4 rdata", held, model[3]);
    araddr = 5'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t4 rstall%0d", i), {rvalid, rdata, rresp, arready}, {1'b1, held, 2'b00, 1'b0});
    end
    arvalid = 1'b0;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;

    // unmapped and status index
    status = 32'hCAFE0001;
    axi_write(5'h14, 32'hFFFFFFFF, 4'hF, "t5 wr14");
    axi_read(5'h14, "t5 rd14");
    axi_write(5'h10, 32'hFFFFFFFF, 4'hF, "t5 wr10");
    axi_read(5'h10, "t5 rd10");
    axi_write(5'h04, 32'h0BADF00D, 4'h0, "t5 strb0");

    // same-cycle read and write of one register
    old1 = model[1];
    @(negedge clk);
    awaddr = 5'h04; wdata = 32'h87654321; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'h04; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model_write(5'h04, 32'h87654321, 4'hF);
    check("rw rdata_old", rdata, old1);
    check("rw reg_new", reg_o, model_flat());
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;

    // reset between AW and W
    @(negedge clk);
    awaddr = 5'h04; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("t6 aw_captured", {awready, wready}, 2'b01);
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    for (int k = 0; k < 4; k++) model[k] = '0;
    check("t6 ready", {awready, wready, arready}, 3'b111);
    check("t6 outs", {bvalid, rvalid, bresp, rresp, rdata, pulse, reg_o}, 170'h0);
    axi_write(5'h04, 32'h600DCAFE, 4'hF, "t6 wr");

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      status = $urandom;
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $sformatf("rnd%0d wr", i));
      else
        axi_read(a, $sformatf("rnd%0d rd", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
